// File: rtl/pockel_spi_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : pockel_spi_pkg
//  Purpose  : Shared constants and types for the board SPI bus arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package pockel_spi_pkg;

   // Default number of SPI requesters on the board
   localparam int NREQ_DEF = 3;

   // Requester index assignment
   localparam int REQ_TFT  = 0;
   localparam int REQ_TS   = 1;
   localparam int REQ_SD   = 2;

   // Arbiter FSM states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GUARD = 2'd2
   } arb_state_t;

endpackage : pockel_spi_pkg
`default_nettype wire

// File: rtl/spi_bus_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick
//  Purpose  : Combinational round-robin picker. Returns the first requester
//             at or after the rr pointer (wrapping), one-hot, plus valid.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
   parameter int NREQ = 3,
   parameter int RW   = 2
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [RW-1:0]   rr_i,
   output logic [NREQ-1:0] win_o,
   output logic            valid_o
);

   // First scan indices >= rr; if none requested, the second scan finds the
   // lowest index, which must then lie below rr (wrap-around order).
   always_comb begin
      win_o   = '0;
      valid_o = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (!valid_o && req_i[i] && (i >= int'(rr_i))) begin
            win_o[i] = 1'b1;
            valid_o  = 1'b1;
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (!valid_o && req_i[i]) begin
            win_o[i] = 1'b1;
            valid_o  = 1'b1;
         end
      end
   end

endmodule : rr_pick
`default_nettype wire

// File: rtl/spi_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : spi_bus_arbiter
//  Purpose  : Shares one SPI bus (SCLK/MOSI/MISO) between several SPI engines.
//             Round-robin grant, registered pin mux, chip-select guard gap
//             between owners and optional per-grant hold timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_bus_arbiter
   import pockel_spi_pkg::*;
#(
   parameter int NREQ         = NREQ_DEF,
   parameter int GUARD_CYCLES = 4,
   parameter int HOLD_MAX     = 0,
   parameter int CPOL         = 0
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] gnt,
   input  logic [NREQ-1:0] m_sclk,
   input  logic [NREQ-1:0] m_mosi,
   input  logic [NREQ-1:0] m_csn,
   output logic            m_miso,
   output logic            SCLK,
   output logic            MOSI,
   input  logic            MISO,
   output logic [NREQ-1:0] csn_pin,
   output logic            timeout
);

   localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int HW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
   localparam int GW = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;

   localparam logic [HW-1:0] c_HOLD_MAX   = HW'(HOLD_MAX);
   localparam logic [GW-1:0] c_GUARD_LAST = GW'(GUARD_CYCLES - 1);
   localparam logic          c_CPOL       = (CPOL != 0);

   arb_state_t      state_q,   state_d;
   logic [NREQ-1:0] gnt_q,     gnt_d;
   logic [NREQ-1:0] csn_q,     csn_d;
   logic [NREQ-1:0] block_q,   block_d;
   logic [RW-1:0]   owner_q,   owner_d;
   logic [RW-1:0]   rr_q,      rr_d;
   logic [HW-1:0]   hold_q,    hold_d;
   logic [GW-1:0]   guard_q,   guard_d;
   logic            sclk_q,    sclk_d;
   logic            mosi_q,    mosi_d;
   logic            timeout_q, timeout_d;

   logic [NREQ-1:0] w_elig;
   logic [NREQ-1:0] w_win;
   logic            w_valid;
   logic [RW-1:0]   w_win_idx;
   logic [RW-1:0]   w_owner_next;
   logic [HW-1:0]   w_hold_inc;
   logic            w_hold_hit;

   // A requester revoked by timeout stays ineligible until its req is seen low
   assign w_elig = req & ~block_q;

   rr_pick #(
      .NREQ (NREQ),
      .RW   (RW)
   ) u_rr_pick (
      .req_i   (w_elig),
      .rr_i    (rr_q),
      .win_o   (w_win),
      .valid_o (w_valid)
   );

   // One-hot winner to index
   always_comb begin
      w_win_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_win[i]) w_win_idx = RW'(i);
      end
   end

   assign w_owner_next = (owner_q == RW'(NREQ - 1)) ? '0 : owner_q + RW'(1);
   assign w_hold_inc   = (hold_q == c_HOLD_MAX) ? hold_q : hold_q + HW'(1);
   assign w_hold_hit   = (HOLD_MAX != 0) && (w_hold_inc == c_HOLD_MAX);

   // MISO is broadcast; only the granted engine is expected to sample it
   assign m_miso  = MISO;
   assign gnt     = gnt_q;
   assign csn_pin = csn_q;
   assign SCLK    = sclk_q;
   assign MOSI    = mosi_q;
   assign timeout = timeout_q;

   // Next-state, grant and registered pin mux decode
   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      csn_d     = csn_q;
      sclk_d    = sclk_q;
      mosi_d    = mosi_q;
      timeout_d = 1'b0;
      owner_d   = owner_q;
      rr_d      = rr_q;
      hold_d    = hold_q;
      guard_d   = guard_q;
      block_d   = block_q & req;

      case (state_q)
         IDLE: begin
            gnt_d  = '0;
            csn_d  = '1;
            sclk_d = c_CPOL;
            mosi_d = 1'b0;
            if (w_valid) begin
               gnt_d   = w_win;
               owner_d = w_win_idx;
               hold_d  = '0;
               state_d = GRANT;
            end
         end

         GRANT: begin
            if (!req[owner_q] || w_hold_hit) begin
               gnt_d   = '0;
               csn_d   = '1;
               sclk_d  = c_CPOL;
               mosi_d  = 1'b0;
               rr_d    = w_owner_next;
               guard_d = '0;
               // Revoked while still requesting: flag it and park the owner
               if (req[owner_q]) begin
                  timeout_d        = 1'b1;
                  block_d[owner_q] = 1'b1;
               end
               if (GUARD_CYCLES == 0) state_d = IDLE;
               else                   state_d = GUARD;
            end else begin
               sclk_d         = m_sclk[owner_q];
               mosi_d         = m_mosi[owner_q];
               csn_d          = '1;
               csn_d[owner_q] = m_csn[owner_q];
               hold_d         = w_hold_inc;
            end
         end

         GUARD: begin
            gnt_d  = '0;
            csn_d  = '1;
            sclk_d = c_CPOL;
            mosi_d = 1'b0;
            if (guard_q == c_GUARD_LAST) state_d = IDLE;
            else                         guard_d = guard_q + GW'(1);
         end

         default: begin
            state_d = IDLE;
            gnt_d   = '0;
            csn_d   = '1;
            sclk_d  = c_CPOL;
            mosi_d  = 1'b0;
         end
      endcase
   end

   // State, counters and pin registers; async reset drops every CSn at once
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= IDLE;
         gnt_q     <= '0;
         csn_q     <= '1;
         sclk_q    <= c_CPOL;
         mosi_q    <= 1'b0;
         timeout_q <= 1'b0;
         owner_q   <= '0;
         rr_q      <= '0;
         hold_q    <= '0;
         guard_q   <= '0;
         block_q   <= '0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         csn_q     <= csn_d;
         sclk_q    <= sclk_d;
         mosi_q    <= mosi_d;
         timeout_q <= timeout_d;
         owner_q   <= owner_d;
         rr_q      <= rr_d;
         hold_q    <= hold_d;
         guard_q   <= guard_d;
         block_q   <= block_d;
      end
   end

endmodule : spi_bus_arbiter
`default_nettype wire

// File: tb/tb_spi_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_bus_arbiter
//  Purpose  : Directed self-checking bench for spi_bus_arbiter. A second
//             instance with HOLD_MAX=16 exercises the grant timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_bus_arbiter;

   logic       clk;
   logic       rstn;

   logic [2:0] req, m_sclk, m_mosi, m_csn, gnt, csn_pin;
   logic       MISO, m_miso, SCLK, MOSI, timeout;

   logic [2:0] t_req, t_m_sclk, t_m_mosi, t_m_csn, t_gnt, t_csn_pin;
   logic       t_MISO, t_m_miso, t_SCLK, t_MOSI, t_timeout;

   int n_checks = 0;
   int n_fail   = 0;

   spi_bus_arbiter #(
      .NREQ(3), .GUARD_CYCLES(4), .HOLD_MAX(0), .CPOL(0)
   ) u_dut (
      .clk(clk), .rstn(rstn), .req(req), .gnt(gnt),
      .m_sclk(m_sclk), .m_mosi(m_mosi), .m_csn(m_csn), .m_miso(m_miso),
      .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .csn_pin(csn_pin), .timeout(timeout)
   );

   spi_bus_arbiter #(
      .NREQ(3), .GUARD_CYCLES(4), .HOLD_MAX(16), .CPOL(0)
   ) u_dut_to (
      .clk(clk), .rstn(rstn), .req(t_req), .gnt(t_gnt),
      .m_sclk(t_m_sclk), .m_mosi(t_m_mosi), .m_csn(t_m_csn), .m_miso(t_m_miso),
      .SCLK(t_SCLK), .MOSI(t_MOSI), .MISO(t_MISO), .csn_pin(t_csn_pin), .timeout(t_timeout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      req  = 3'b111;
      repeat (3) tick();
      n_checks++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL reset_gnt: got %b want 000", gnt); end
      n_checks++; if (csn_pin !== 3'b111) begin n_fail++; $display("FAIL reset_csn: got %b want 111", csn_pin); end
      n_checks++; if ({SCLK, MOSI, timeout} !== 3'b000) begin n_fail++; $display("FAIL reset_sclk_mosi_to: got %b want 000", {SCLK, MOSI, timeout}); end
      rstn = 1'b1;
      tick();
      n_checks++; if (gnt !== 3'b001) begin n_fail++; $display("FAIL reset_first_gnt: got %b want 001", gnt); end
      n_checks++; if (csn_pin !== 3'b111) begin n_fail++; $display("FAIL reset_pin_lag: got %b want 111", csn_pin); end
      req = 3'b000;
      tick();
      n_checks++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL reset_release: got %b want 000", gnt); end
      repeat (6) tick();
   endtask

   // rr is 1 on entry; only requester 2 asks
   task automatic test_single_owner();
      logic [2:0] pats [4];
      logic [2:0] prev;
      pats = '{3'b010, 3'b101, 3'b000, 3'b110};
      prev = 3'b001;
      req  = 3'b100;
      tick();
      n_checks++; if (gnt !== 3'b100) begin n_fail++; $display("FAIL single_gnt: got %b want 100", gnt); end
      for (int k = 0; k < 4; k++) begin
         m_sclk[2] = pats[k][2];
         m_mosi[2] = pats[k][1];
         m_csn     = {pats[k][0], 2'b00};
         n_checks++;
         if ({SCLK, MOSI, csn_pin[2]} !== prev) begin
            n_fail++; $display("FAIL single_lag[%0d]: got %b want %b", k, {SCLK, MOSI, csn_pin[2]}, prev);
         end
         tick();
         n_checks++;
         if ({SCLK, MOSI, csn_pin} !== {pats[k][2], pats[k][1], pats[k][0], 2'b11}) begin
            n_fail++; $display("FAIL single_pins[%0d]: got %b want %b", k, {SCLK, MOSI, csn_pin}, {pats[k][2], pats[k][1], pats[k][0], 2'b11});
         end
         prev = pats[k];
      end
      MISO = 1'b1; #1;
      n_checks++; if (m_miso !== 1'b1) begin n_fail++; $display("FAIL miso_hi: got %b want 1", m_miso); end
      MISO = 1'b0; #1;
      n_checks++; if (m_miso !== 1'b0) begin n_fail++; $display("FAIL miso_lo: got %b want 0", m_miso); end
      req = 3'b000;
      tick();
      n_checks++;
      if ({gnt, csn_pin, SCLK, MOSI} !== 8'b000_111_0_0) begin
         n_fail++; $display("FAIL single_release: got %b want 00011100", {gnt, csn_pin, SCLK, MOSI});
      end
      m_sclk = 3'b000; m_mosi = 3'b000; m_csn = 3'b111;
      repeat (6) tick();
   endtask

   // rr is 0 on entry (wrapped from owner 2)
   task automatic test_round_robin();
      int exp_order [4];
      exp_order = '{0, 1, 2, 0};
      req = 3'b111;
      for (int k = 0; k < 4; k++) begin
         int gap;
         int w;
         gap = 0;
         while (gnt === 3'b000 && gap < 40) begin tick(); gap++; end
         w = exp_order[k];
         n_checks++; if (gnt !== (3'b001 << w)) begin n_fail++; $display("FAIL rr_owner[%0d]: got %b want %b", k, gnt, 3'b001 << w); end
         n_checks++;
         if (gap !== ((k == 0) ? 1 : 5)) begin
            n_fail++; $display("FAIL rr_gap[%0d]: got %0d want %0d", k, gap, (k == 0) ? 1 : 5);
         end
         repeat (9) tick();
         n_checks++; if (gnt !== (3'b001 << w)) begin n_fail++; $display("FAIL rr_hold[%0d]: got %b want %b", k, gnt, 3'b001 << w); end
         req[w] = 1'b0;
         tick();
         n_checks++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL rr_drop[%0d]: got %b want 000", k, gnt); end
         req[w] = 1'b1;
      end
      req = 3'b000;
      repeat (6) tick();
      n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL no_timeout: got %b want 0", timeout); end
   endtask

   task automatic test_guard();
      int   cyc;
      logic guard_ok;
      req = 3'b001;
      tick();
      n_checks++; if (gnt !== 3'b001) begin n_fail++; $display("FAIL guard_gnt0: got %b want 001", gnt); end
      repeat (3) tick();
      req = 3'b000;
      tick();
      m_csn    = 3'b000;
      cyc      = 0;
      guard_ok = 1'b1;
      while (gnt === 3'b000 && cyc < 40) begin
         if (csn_pin !== 3'b111) guard_ok = 1'b0;
         if (cyc == 2) req = 3'b010;
         tick();
         cyc++;
      end
      n_checks++; if (cyc !== 5) begin n_fail++; $display("FAIL guard_gap: got %0d want 5", cyc); end
      n_checks++; if (gnt !== 3'b010) begin n_fail++; $display("FAIL guard_gnt1: got %b want 010", gnt); end
      n_checks++; if (guard_ok !== 1'b1) begin n_fail++; $display("FAIL guard_csn_low: got %b want 1", guard_ok); end
      tick();
      n_checks++; if (csn_pin !== 3'b101) begin n_fail++; $display("FAIL guard_owner_csn: got %b want 101", csn_pin); end
      req   = 3'b000;
      m_csn = 3'b111;
      repeat (7) tick();
   endtask

   task automatic test_timeout();
      int   n;
      logic early;
      logic regrant;
      t_req = 3'b101;
      tick();
      n_checks++; if (t_gnt !== 3'b001) begin n_fail++; $display("FAIL to_gnt0: got %b want 001", t_gnt); end
      n     = 0;
      early = 1'b0;
      while (t_gnt[0] === 1'b1 && n < 40) begin
         if (t_timeout !== 1'b0) early = 1'b1;
         tick();
         n++;
      end
      n_checks++; if (n !== 16) begin n_fail++; $display("FAIL to_len: got %0d want 16", n); end
      n_checks++; if (early !== 1'b0) begin n_fail++; $display("FAIL to_early: got %b want 0", early); end
      n_checks++; if ({t_timeout, t_gnt} !== 4'b1_000) begin n_fail++; $display("FAIL to_pulse: got %b want 1000", {t_timeout, t_gnt}); end
      tick();
      n_checks++; if (t_timeout !== 1'b0) begin n_fail++; $display("FAIL to_pulse_width: got %b want 0", t_timeout); end
      n = 1;
      while (t_gnt === 3'b000 && n < 40) begin tick(); n++; end
      n_checks++; if (n !== 5) begin n_fail++; $display("FAIL to_gap: got %0d want 5", n); end
      n_checks++; if (t_gnt !== 3'b100) begin n_fail++; $display("FAIL to_gnt2: got %b want 100", t_gnt); end
      repeat (2) tick();
      t_req = 3'b001;
      tick();
      n_checks++; if (t_gnt !== 3'b000) begin n_fail++; $display("FAIL to_drop2: got %b want 000", t_gnt); end
      regrant = 1'b0;
      repeat (12) begin
         tick();
         if (t_gnt !== 3'b000) regrant = 1'b1;
      end
      n_checks++; if (regrant !== 1'b0) begin n_fail++; $display("FAIL to_blocked: got %b want 0", regrant); end
      t_req = 3'b000;
      tick();
      t_req = 3'b001;
      n = 0;
      while (t_gnt === 3'b000 && n < 10) begin tick(); n++; end
      n_checks++; if ({n[3:0], t_gnt} !== {4'd1, 3'b001}) begin n_fail++; $display("FAIL to_unblock: got lat %0d gnt %b want lat 1 gnt 001", n, t_gnt); end
      t_req = 3'b000;
      repeat (6) tick();
   endtask

   // rr is 2 on entry; only requester 1 asks
   task automatic test_async_reset();
      req = 3'b010;
      tick();
      n_checks++; if (gnt !== 3'b010) begin n_fail++; $display("FAIL ar_gnt: got %b want 010", gnt); end
      m_sclk[1] = 1'b1;
      m_csn[1]  = 1'b0;
      tick();
      n_checks++; if ({SCLK, csn_pin} !== 4'b1_101) begin n_fail++; $display("FAIL ar_pins: got %b want 1101", {SCLK, csn_pin}); end
      #3;
      rstn = 1'b0;
      #1;
      n_checks++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL ar_gnt_async: got %b want 000", gnt); end
      n_checks++; if ({SCLK, csn_pin} !== 4'b0_111) begin n_fail++; $display("FAIL ar_pins_async: got %b want 0111", {SCLK, csn_pin}); end
      req    = 3'b000;
      m_sclk = 3'b000;
      m_csn  = 3'b111;
      tick();
      rstn = 1'b1;
      tick();
      n_checks++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL ar_after: got %b want 000", gnt); end
   endtask

   initial begin
      rstn     = 1'b0;
      req      = 3'b000;
      m_sclk   = 3'b000;
      m_mosi   = 3'b000;
      m_csn    = 3'b111;
      MISO     = 1'b0;
      t_req    = 3'b000;
      t_m_sclk = 3'b000;
      t_m_mosi = 3'b000;
      t_m_csn  = 3'b111;
      t_MISO   = 1'b0;

      test_reset();
      test_single_owner();
      test_round_robin();
      test_guard();
      test_timeout();
      test_async_reset();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_spi_bus_arbiter
`default_nettype wire
